// File: rtl/alu_issue_pkg.sv
// ----------------------------------------------------------------------------
// Package : alu_issue_pkg
// Desc    : Shared widths, FSM state type and command layout for alu_issue_unit.
// Rev     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_issue_pkg;

  localparam int ALU_DW   = 8;
  localparam int ALU_SELW = 4;
  localparam int TAG_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ALU_SELW-1:0] sel;
    logic [ALU_DW-1:0]   a;
    logic [ALU_DW-1:0]   b;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
// ----------------------------------------------------------------------------
// Module : alu_cmd_fifo
// Desc   : Power-of-two circular command FIFO with registered occupancy count.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wptr;
  logic [c_AW-1:0]  r_rptr;
  logic [c_CW-1:0]  r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == c_CW'(DEPTH));
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && (r_count != '0);
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = w_full;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + c_CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - c_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_unit.sv
// ----------------------------------------------------------------------------
// Module : alu_issue_unit
// Desc   : Queues ALU commands, issues one per ISSUE cycle to ALU_8bit and holds
//          the registered result on a valid/ready port. Option: ALU_ISSUE_TAG_EN.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ALU_DW-1:0]   cmd_a,
  input  logic [ALU_DW-1:0]   cmd_b,
  input  logic [ALU_SELW-1:0] cmd_sel,
  output logic [ALU_DW-1:0]   alu_a,
  output logic [ALU_DW-1:0]   alu_b,
  output logic [ALU_SELW-1:0] alu_sel,
  input  logic [ALU_DW-1:0]   alu_out,
  input  logic                alu_carry,
  input  logic                alu_zero,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ALU_DW-1:0]   res_data,
  output logic                res_carry,
`ifdef ALU_ISSUE_TAG_EN
  output logic [TAG_W-1:0]    res_tag,
`endif
  output logic                res_zero
);

  localparam int c_CW = $clog2(DEPTH+1);
`ifdef ALU_ISSUE_TAG_EN
  localparam int c_ENTRY_W = TAG_W + $bits(cmd_t);
`else
  localparam int c_ENTRY_W = $bits(cmd_t);
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  cmd_t                  w_cmd_in;
  cmd_t                  w_head_cmd;
  logic [c_ENTRY_W-1:0]  w_entry_in;
  logic [c_ENTRY_W-1:0]  w_entry_head;
  logic [c_CW-1:0]       w_count;
  logic                  w_full;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_has_cmd;
  logic [ALU_DW-1:0]     r_res_data;
  logic                  r_res_carry;
  logic                  r_res_zero;

  assign cmd_ready     = !w_full;
  assign w_push        = cmd_valid && cmd_ready;
  assign w_issue       = (r_state == ISSUE);
  assign w_has_cmd     = (w_count != '0);
  assign w_cmd_in.sel  = cmd_sel;
  assign w_cmd_in.a    = cmd_a;
  assign w_cmd_in.b    = cmd_b;

`ifdef ALU_ISSUE_TAG_EN
  logic [TAG_W-1:0] r_tag_ctr;
  logic [TAG_W-1:0] r_res_tag;
  logic [TAG_W-1:0] w_head_tag;

  assign w_entry_in               = {r_tag_ctr, w_cmd_in};
  assign {w_head_tag, w_head_cmd} = w_entry_head;
  assign res_tag                  = r_res_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_ctr <= '0;
      r_res_tag <= '0;
    end else begin
      if (w_push)  r_tag_ctr <= r_tag_ctr + TAG_W'(1);
      if (w_issue) r_res_tag <= w_head_tag;
    end
  end
`else
  assign w_entry_in = w_cmd_in;
  assign w_head_cmd = w_entry_head;
`endif

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_entry_in),
    .i_pop   (w_issue),
    .o_head  (w_entry_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  // ALU inputs are forced to zero except during the single ISSUE cycle.
  assign alu_a   = w_issue ? w_head_cmd.a   : '0;
  assign alu_b   = w_issue ? w_head_cmd.b   : '0;
  assign alu_sel = w_issue ? w_head_cmd.sel : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_has_cmd) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = HOLD;
      HOLD:    if (res_ready) w_state_nxt = w_has_cmd ? ISSUE : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_res_zero  <= 1'b0;
    end else if (w_issue) begin
      r_res_data  <= alu_out;
      r_res_carry <= alu_carry;
      r_res_zero  <= alu_zero;
    end
  end

  assign res_valid = (r_state == HOLD);
  assign res_data  = r_res_data;
  assign res_carry = r_res_carry;
  assign res_zero  = r_res_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
// ----------------------------------------------------------------------------
// Module : tb_alu_issue_unit
// Desc   : Directed + random bench for alu_issue_unit with an adder stub ALU.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_unit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [3:0] cmd_sel;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry, alu_zero;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       res_carry, res_zero;
`ifdef ALU_ISSUE_TAG_EN
  logic [3:0] res_tag;
`endif

  always #5 clk = ~clk;

  logic [8:0] w_sum;
  assign w_sum     = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_out   = w_sum[7:0];
  assign alu_carry = w_sum[8];
  assign alu_zero  = (w_sum[7:0] == 8'h00);

  alu_issue_unit #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .alu_zero  (alu_zero),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
`ifdef ALU_ISSUE_TAG_EN
    .res_tag   (res_tag),
`endif
    .res_zero  (res_zero)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [3:0] tag;
  } exp_t;

  exp_t       q[$];
  logic [3:0] tag_model;
  logic       acc;
  int         n_checks;
  int         n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes seen before the edge, then advance past it.
  task automatic tick();
    logic        do_push, do_pop, was_hold;
    logic [9:0]  held;
    logic [8:0]  s;
    exp_t        e;
    do_push  = cmd_valid && cmd_ready;
    do_pop   = res_valid && res_ready;
    was_hold = res_valid && !res_ready;
    held     = {res_data, res_carry, res_zero};
    if (res_valid)
      chk("alu_quiet_hold", {alu_a, alu_b, alu_sel}, 32'h0);
    else if ({alu_a, alu_b, alu_sel} != 20'h0)
      chk("alu_issue_head", {alu_a, alu_b, alu_sel},
          (q.size() > 0) ? {12'h0, q[0].a, q[0].b, q[0].sel} : 32'h8000_0000);
    if (do_pop) begin
      if (q.size() == 0) begin
        chk("res_spurious", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        s = {1'b0, e.a} + {1'b0, e.b};
        chk("res_data",  res_data,  s[7:0]);
        chk("res_carry", res_carry, s[8]);
        chk("res_zero",  res_zero,  (s[7:0] == 8'h00));
`ifdef ALU_ISSUE_TAG_EN
        chk("res_tag",   res_tag,   e.tag);
`endif
      end
    end
    if (do_push) begin
      e.a = cmd_a; e.b = cmd_b; e.sel = cmd_sel; e.tag = tag_model;
      q.push_back(e);
      tag_model = tag_model + 4'd1;
    end
    acc = do_push;
    @(posedge clk);
    #1;
    if (do_push) cmd_valid = 1'b0;
    if (was_hold)
      chk("res_stable", {res_valid, res_data, res_carry, res_zero}, {1'b1, held});
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) tick();
    if (!acc) begin
      chk("push_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    res_ready = 1'b1;
    for (int i = 0; i < 200 && (q.size() > 0 || res_valid); i++) tick();
    chk("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    n_checks = 0; n_err = 0; tag_model = 4'd0; acc = 1'b0;
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = 8'h0; cmd_b = 8'h0; cmd_sel = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_alu", {alu_a, alu_b, alu_sel}, 32'h0);
    chk("rst_res", {res_data, res_carry, res_zero}, 32'h0);
`ifdef ALU_ISSUE_TAG_EN
    chk("rst_tag", res_tag, 4'h0);
`endif
    rst_n = 1'b1;
    tick();

    // Accepted at edge N: IDLE, then ISSUE for one cycle, then HOLD.
    res_ready = 1'b1;
    cmd_a = 8'h0A; cmd_b = 8'h05; cmd_sel = 4'h0; cmd_valid = 1'b1;
    tick();
    chk("t1_acc", acc, 1'b1);
    chk("t1_idle_alu", {alu_a, alu_b, alu_sel}, 32'h0);
    tick();
    chk("t1_issue_alu", {alu_a, alu_b, alu_sel}, {12'h0, 8'h0A, 8'h05, 4'h0});
    chk("t1_issue_nvalid", res_valid, 1'b0);
    tick();
    chk("t1_valid", res_valid, 1'b1);
    chk("t1_data", {res_data, res_carry, res_zero}, {8'h0F, 1'b0, 1'b0});
    chk("t1_alu_quiet", {alu_a, alu_b, alu_sel}, 32'h0);
    tick();
    chk("t1_consumed", res_valid, 1'b0);

    push(8'hFF, 8'h01, 4'h3);
    for (int i = 0; i < 10 && !res_valid; i++) tick();
    chk("t2_data", {res_valid, res_data, res_carry, res_zero}, {1'b1, 8'h00, 1'b1, 1'b1});
    drain();

    // Back-pressure: one command sits in the result register, DEPTH in the FIFO.
    res_ready = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 10 && cmd_ready; k++) begin
      cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_sel = 4'(k); cmd_valid = 1'b1;
      tick();
      if (acc) n_acc++;
    end
    chk("t3_accepted", n_acc, DEPTH + 1);
    cmd_a = 8'h80; cmd_b = 8'h80; cmd_sel = 4'hF; cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_full_ready", cmd_ready, 1'b0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("t3_ready_issue", cmd_ready, 1'b0);
    tick();
    chk("t3_ready_after_pop", cmd_ready, 1'b1);
    drain();

    for (int k = 0; k < 10; k++)
      push(8'($urandom), 8'($urandom), 4'(k));
    drain();

    for (int k = 0; k < 80; k++) begin
      if (!cmd_valid && ($urandom_range(0, 1) == 1)) begin
        cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_sel = 4'($urandom);
        cmd_valid = 1'b1;
      end
      res_ready = 1'($urandom_range(0, 1));
      tick();
    end
    cmd_valid = 1'b0;
    drain();

    // Reset while holding a result with three more queued.
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(8'($urandom), 8'($urandom), 4'(k));
    chk("t5_hold", res_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", res_valid, 1'b0);
    chk("t5_rst_ready", cmd_ready, 1'b1);
    chk("t5_rst_data", {res_data, res_carry, res_zero}, 32'h0);
    q.delete();
    tag_model = 4'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_no_stale", res_valid, 1'b0);
    end

    for (int k = 0; k < 17; k++) push(8'($urandom), 8'($urandom), 4'($urandom));
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
